lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Parametrised load/store controller for the MW stage of the two-stage RV32I/RV64I core. It supersedes the single-cycle load/store path with a request/valid handshake to a variable-latency data memory. It generates byte masks and lane-aligned store data, sign- or zero-extends load data, and holds the pipeline stalled until memory responds. A timeout turns a hung access into a fault instead of a deadlock.

## Interface
- XLEN, 32, data and address width; legal values are 32 and 64.
- TIMEOUT, 16, maximum WAIT cycles before the access is aborted; 0 disables the timeout.
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  MW stage holds a valid instruction.
- opcode  in  7  MW-stage opcode: 0000011 is load, 0100011 is store, any other opcode is ignored.
- funct3  in  3  access size and sign.
- addr_in  in  XLEN  effective address (the ALU result).
- wdata_in  in  XLEN  store source (rs2).
- stall  out  1  hold PC and both pipeline registers.
- done  out  1  one-cycle pulse when the access completes.
- fault  out  1  one-cycle pulse coincident with done on an aborted access.
- rdata  out  XLEN  formatted load result; valid while done=1.
- mem_cs  out  1  memory request.
- mem_wr  out  1  1 = write.
- mem_mask  out  XLEN/8  byte enables.
- mem_addr  out  XLEN  address, aligned to XLEN/8 bytes.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_valid  in  1  memory response or acknowledge.
- mem_rdata  in  XLEN  raw read word.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - A memory op is req_valid=1 with a load or store opcode.
  - When a memory op is present, stall=1 combinationally in the same cycle.
  - The request fields are registered into the mem_* outputs, and the FSM moves to WAIT.
  - A non-memory opcode, or req_valid=0, causes no action and stall=0.
- WAIT:
  - mem_cs=1 and all mem_* outputs are held stable.
  - mem_valid=1 → capture formatted rdata and move to DONE.
  - The wait counter increments every WAIT cycle.
  - If the counter reaches TIMEOUT with mem_valid=0 → move to DONE with fault=1 and rdata=0.
  - If mem_valid and the timeout fall in the same cycle, mem_valid wins.
- DONE:
  - stall=0, done=1, mem_cs=0, and the FSM returns to IDLE.
  - req_valid is ignored in DONE, because the same instruction is still present that cycle.
- Store lane generation, with off = addr_in[log2(XLEN/8)-1:0]:
  - SB: byte replicated across all lanes; mask bit [off] set.
  - SH: halfword replicated; mask 2'b11 placed at lane (off & ~1).
  - SW: word replicated; mask 4'hF placed at lane (off & ~3).
  - SD (XLEN=64 only): all-ones mask.
- Loads drive an all-ones mask and mem_wr=0.
- Load formatting from the selected lane of mem_rdata:
  - LB and LH are sign-extended to XLEN.
  - LBU and LHU are zero-extended.
  - LW is sign-extended when XLEN=64; LWU (XLEN=64) is zero-extended.
  - LD passes through unchanged.
- Unsupported funct3 values are treated as a full-width access.
- Without LSU_MISALIGN_TRAP_EN, misaligned low address bits are silently truncated to the access size.

## Timing
- All outputs are 0 at reset, and the FSM resets to IDLE.
- Reset asserted mid-access drops mem_cs immediately (asynchronously); no done or fault is issued for that access.
- Minimum access, with mem_valid combinationally high on the cycle mem_cs rises:
  - Cycle T: op seen in IDLE, stall=1.
  - Cycle T+1: WAIT, mem_cs=1.
  - Cycle T+2: DONE, stall=0.
  - Total: 2 stalled cycles.
- A memory latency of L cycles in WAIT costs L+1 stalled cycles.
- Back-to-back memory ops: the next op is accepted the cycle after DONE, with no extra bubble.
- The counter clears on entry to WAIT; a timeout pulses fault on the DONE cycle after TIMEOUT WAIT cycles.
- The memory must not assert mem_valid outside WAIT; such a pulse is ignored.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access (LH/LHU/SH with odd address, LW/LWU/SW with address mod 4 ≠ 0, LD/SD with address mod 8 ≠ 0) skips memory entirely.
  - The FSM goes IDLE→DONE with fault=1 and rdata=0; mem_cs is never asserted.
  - Cost: 1 stall cycle.
- LSU_MISALIGN_TRAP_EN undefined:
  - No misalignment check is made; low address bits are truncated.
  - fault is raised only by a timeout.

## Test plan
- LW at 0x100, memory acknowledges in the same cycle with mem_rdata=0xDEADBEEF → stall high for 2 cycles, done pulse, rdata=0xDEADBEEF.
- SB at 0x203 with wdata 0x000000A5, XLEN=32 → mem_mask=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200, mem_wr=1.
- LB at 0x1, mem_rdata=0x00008000 → rdata=0xFFFFFF80; LBU at the same address → 0x00000080.
- mem_valid delayed 5 cycles, TIMEOUT=16 → 6 stall cycles, no fault; with mem_valid never asserted → fault and done on the cycle after 16 WAIT cycles, rdata=0.
- rst pulled low during WAIT → mem_cs=0 and stall=0 immediately; after release, the next LW completes normally.
- With LSU_MISALIGN_TRAP_EN defined, SH at 0x101 → mem_cs never asserted, 1 stall cycle, fault=1 with done.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller with a request/valid handshake to a variable-latency data memory.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   addr_in,
   input  logic [XLEN-1:0]   wdata_in,
   output logic              stall,
   output logic              done,
   output logic              fault,
   output logic [XLEN-1:0]   rdata,
   output logic              mem_cs,
   output logic              mem_wr,
   output logic [XLEN/8-1:0] mem_mask,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_valid,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_F} size_t;

   state_t          state, next_state;
   size_t           sz, sz_q;
   logic            uns, uns_q;
   logic [OW-1:0]   off, amask, lane, lane_q;
   logic [CW-1:0]   wait_cnt;
   logic            fault_q;
   logic [XLEN-1:0] rdata_q, shifted, fmt, wdata_d;
   logic [NB-1:0]   mask_d;
   logic            is_load, is_store, mem_op;
   logic            accept, trap, timeout_hit, stall_c;

   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign mem_op   = req_valid && (is_load || is_store);
   assign off      = addr_in[OW-1:0];

   // Access size from funct3; anything not legal for this XLEN becomes a full-width access.
   always_comb begin
      sz  = SZ_F;
      uns = 1'b0;
      if (is_load) begin
         case (funct3)
            3'd0: sz = SZ_B;
            3'd1: sz = SZ_H;
            3'd2: sz = SZ_W;
            3'd4: begin sz = SZ_B; uns = 1'b1; end
            3'd5: begin sz = SZ_H; uns = 1'b1; end
            3'd6: if (XLEN == 64) begin sz = SZ_W; uns = 1'b1; end
            default: sz = SZ_F;
         endcase
      end else begin
         case (funct3)
            3'd0:    sz = SZ_B;
            3'd1:    sz = SZ_H;
            3'd2:    sz = SZ_W;
            default: sz = SZ_F;
         endcase
      end
   end

   // Lane offset is the byte offset with the sub-size bits dropped, so misalignment truncates.
   always_comb begin
      amask   = '0;
      mask_d  = '1;
      wdata_d = wdata_in;
      case (sz)
         SZ_B: begin
            amask   = '1;
            mask_d  = NB'(1) << lane;
            wdata_d = {NB{wdata_in[7:0]}};
         end
         SZ_H: begin
            amask   = ~OW'(1);
            mask_d  = NB'(3) << lane;
            wdata_d = {(NB/2){wdata_in[15:0]}};
         end
         SZ_W: begin
            amask   = ~OW'(3);
            mask_d  = NB'(15) << lane;
            wdata_d = {(NB/4){wdata_in[31:0]}};
         end
         default: begin
            amask   = '0;
            mask_d  = '1;
            wdata_d = wdata_in;
         end
      endcase
   end

   assign lane = off & amask;

   always_comb begin
      shifted = mem_rdata >> {lane_q, 3'b000};
      fmt     = shifted;
      case (sz_q)
         SZ_B: if (uns_q) fmt = XLEN'(shifted[7:0]);
               else       fmt = XLEN'($signed(shifted[7:0]));
         SZ_H: if (uns_q) fmt = XLEN'(shifted[15:0]);
               else       fmt = XLEN'($signed(shifted[15:0]));
         SZ_W: if (uns_q) fmt = XLEN'(shifted[31:0]);
               else       fmt = XLEN'($signed(shifted[31:0]));
         default: fmt = shifted;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   // Next state plus the accept/trap strobes that steer the datapath registers.
   always_comb begin
      next_state = state;
      stall_c    = 1'b0;
      accept     = 1'b0;
      trap       = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_op) begin
               stall_c = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
               if ((off & ~amask) != '0) begin
                  trap       = 1'b1;
                  next_state = S_DONE;
               end else
`endif
               begin
                  accept     = 1'b1;
                  next_state = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            stall_c = 1'b1;
            if (mem_valid || timeout_hit) next_state = S_DONE;
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_wr    <= 1'b0;
         mem_mask  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         sz_q      <= SZ_B;
         uns_q     <= 1'b0;
         lane_q    <= '0;
         wait_cnt  <= '0;
         fault_q   <= 1'b0;
         rdata_q   <= '0;
      end else if (accept) begin
         mem_wr    <= is_store;
         mem_mask  <= is_store ? mask_d : '1;
         mem_addr  <= {addr_in[XLEN-1:OW], {OW{1'b0}}};
         mem_wdata <= is_store ? wdata_d : '0;
         sz_q      <= sz;
         uns_q     <= uns;
         lane_q    <= lane;
         wait_cnt  <= '0;
         fault_q   <= 1'b0;
         rdata_q   <= '0;
      end else if (trap) begin
         fault_q <= 1'b1;
         rdata_q <= '0;
      end else if (state == S_WAIT) begin
         wait_cnt <= wait_cnt + CW'(1);
         if (mem_valid) begin
            rdata_q <= mem_wr ? '0 : fmt;
            fault_q <= 1'b0;
         end else if (timeout_hit) begin
            rdata_q <= '0;
            fault_q <= 1'b1;
         end
      end
   end

   // Reset gates stall so an in-flight access releases the pipeline immediately.
   assign stall  = rst && stall_c;
   assign mem_cs = (state == S_WAIT);
   assign done   = (state == S_DONE);
   assign fault  = (state == S_DONE) && fault_q;
   assign rdata  = (state == S_DONE) ? rdata_q : '0;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl (XLEN=32, TIMEOUT=16): vector table plus corner sequences.
// Build with LSU_MISALIGN_TRAP_EN defined to exercise the misaligned-trap path.
module tb_lsu_mem_ctrl;
   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr_in = '0;
   logic [31:0] wdata_in = '0;
   logic        stall, done, fault;
   logic [31:0] rdata;
   logic        mem_cs, mem_wr;
   logic [3:0]  mem_mask;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;

   int          n_stall, n_cs;
   logic        saw_done, cap_fault, cap_wr, cs_unstable;
   logic [3:0]  cap_mask;
   logic [31:0] cap_rdata, cap_addr, cap_wdata;

   lsu_mem_ctrl #(.XLEN(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .opcode(opcode), .funct3(funct3),
      .addr_in(addr_in), .wdata_in(wdata_in), .stall(stall), .done(done), .fault(fault),
      .rdata(rdata), .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_mask(mem_mask),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      logic        exp_wr;
      logic [3:0]  exp_mask;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[13];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One access; lat>0 raises mem_valid on the lat-th WAIT cycle, lat=0 never responds.
   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input int lat);
      @(negedge clk);
      req_valid = 1'b1; opcode = op; funct3 = f3; addr_in = a; wdata_in = wd;
      mem_rdata = rd; mem_valid = 1'b0;
      n_stall = 0; n_cs = 0; saw_done = 1'b0; cap_fault = 1'b0; cap_rdata = '0;
      cs_unstable = 1'b0;
      for (int c = 0; c < 64 && !saw_done; c++) begin
         #1;
         if (stall) n_stall++;
         if (mem_cs) begin
            n_cs++;
            if (n_cs == 1) begin
               cap_wr = mem_wr; cap_mask = mem_mask; cap_addr = mem_addr; cap_wdata = mem_wdata;
            end else if (mem_wr !== cap_wr || mem_mask !== cap_mask ||
                         mem_addr !== cap_addr || mem_wdata !== cap_wdata) begin
               cs_unstable = 1'b1;
            end
            mem_valid = (lat > 0) && (n_cs == lat);
         end else begin
            mem_valid = 1'b0;
         end
         if (done) begin
            saw_done = 1'b1; cap_fault = fault; cap_rdata = rdata;
         end else begin
            @(negedge clk);
         end
      end
      mem_valid = 1'b0;
      req_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{"lw",    LOAD,  3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF};
      vecs[1]  = '{"sb",    STORE, 3'd0, 32'h203, 32'h000000A5, 32'h0,        1'b1, 4'h8, 32'h200, 32'hA5A5A5A5, 32'h0};
      vecs[2]  = '{"lb",    LOAD,  3'd0, 32'h1,   32'h0,        32'h00008000, 1'b0, 4'hF, 32'h0,   32'h0,        32'hFFFFFF80};
      vecs[3]  = '{"lbu",   LOAD,  3'd4, 32'h1,   32'h0,        32'h00008000, 1'b0, 4'hF, 32'h0,   32'h0,        32'h00000080};
      vecs[4]  = '{"sh",    STORE, 3'd1, 32'h102, 32'h1234ABCD, 32'h0,        1'b1, 4'hC, 32'h100, 32'hABCDABCD, 32'h0};
      vecs[5]  = '{"lh",    LOAD,  3'd1, 32'h2,   32'h0,        32'h80017FFF, 1'b0, 4'hF, 32'h0,   32'h0,        32'hFFFF8001};
      vecs[6]  = '{"lhu",   LOAD,  3'd5, 32'h2,   32'h0,        32'h80017FFF, 1'b0, 4'hF, 32'h0,   32'h0,        32'h00008001};
      vecs[7]  = '{"sw",    STORE, 3'd2, 32'h304, 32'hCAFEF00D, 32'h0,        1'b1, 4'hF, 32'h304, 32'hCAFEF00D, 32'h0};
      vecs[8]  = '{"lb3",   LOAD,  3'd0, 32'h3,   32'h0,        32'h7F000000, 1'b0, 4'hF, 32'h0,   32'h0,        32'h0000007F};
      vecs[9]  = '{"lfull", LOAD,  3'd3, 32'h10,  32'h0,        32'h12345678, 1'b0, 4'hF, 32'h10,  32'h0,        32'h12345678};
      vecs[10] = '{"sb0",   STORE, 3'd0, 32'h0,   32'hFFFFFF5A, 32'h0,        1'b1, 4'h1, 32'h0,   32'h5A5A5A5A, 32'h0};
      vecs[11] = '{"sfull", STORE, 3'd5, 32'h20,  32'h89ABCDEF, 32'h0,        1'b1, 4'hF, 32'h20,  32'h89ABCDEF, 32'h0};
      vecs[12] = '{"lh0",   LOAD,  3'd1, 32'h0,   32'h0,        32'h80017FFF, 1'b0, 4'hF, 32'h0,   32'h0,        32'h00007FFF};

      // Reset state, with a load presented so stall must still read 0.
      req_valid = 1'b1; opcode = LOAD; funct3 = 3'd2; addr_in = 32'h100;
      #3;
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_fault", fault, 0);
      checkOutput("rst_rdata", rdata, 0);
      checkOutput("rst_cs", mem_cs, 0);
      checkOutput("rst_wr", mem_wr, 0);
      checkOutput("rst_mask", mem_mask, 0);
      checkOutput("rst_addr", mem_addr, 0);
      checkOutput("rst_wdata", mem_wdata, 0);
      @(negedge clk); @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;

      // Table vectors, back-to-back, memory answering on the first WAIT cycle.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].mrdata, 1);
         checkOutput({vecs[i].name, "_done"}, saw_done, 1);
         checkOutput({vecs[i].name, "_fault"}, cap_fault, 0);
         checkOutput({vecs[i].name, "_stalls"}, n_stall, 2);
         checkOutput({vecs[i].name, "_cs_cycles"}, n_cs, 1);
         checkOutput({vecs[i].name, "_wr"}, cap_wr, vecs[i].exp_wr);
         checkOutput({vecs[i].name, "_mask"}, cap_mask, vecs[i].exp_mask);
         checkOutput({vecs[i].name, "_addr"}, cap_addr, vecs[i].exp_addr);
         if (vecs[i].exp_wr) checkOutput({vecs[i].name, "_wdata"}, cap_wdata, vecs[i].exp_wdata);
         else                checkOutput({vecs[i].name, "_rdata"}, cap_rdata, vecs[i].exp_rdata);
      end

      // Five-cycle memory latency.
      applyStimulus(LOAD, 3'd2, 32'h400, 32'h0, 32'h0BADF00D, 5);
      checkOutput("lat5_done", saw_done, 1);
      checkOutput("lat5_stalls", n_stall, 6);
      checkOutput("lat5_fault", cap_fault, 0);
      checkOutput("lat5_rdata", cap_rdata, 32'h0BADF00D);

      // No response: timeout after 16 WAIT cycles.
      applyStimulus(STORE, 3'd1, 32'h502, 32'h0000BEEF, 32'h0, 0);
      checkOutput("tmo_done", saw_done, 1);
      checkOutput("tmo_fault", cap_fault, 1);
      checkOutput("tmo_cs_cycles", n_cs, 16);
      checkOutput("tmo_stalls", n_stall, 17);
      checkOutput("tmo_rdata", cap_rdata, 0);
      checkOutput("tmo_stable", cs_unstable, 0);
      checkOutput("tmo_mask", cap_mask, 4'hC);

      // Non-memory opcode and a stray mem_valid in IDLE must both be ignored.
      @(negedge clk);
      req_valid = 1'b1; opcode = 7'b0110011; mem_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checkOutput("nop_stall", stall, 0);
         checkOutput("nop_cs", mem_cs, 0);
         checkOutput("nop_done", done, 0);
         @(negedge clk);
      end
      req_valid = 1'b0; mem_valid = 1'b0;

      // Reset pulled during WAIT.
      @(negedge clk);
      req_valid = 1'b1; opcode = LOAD; funct3 = 3'd2; addr_in = 32'h40; mem_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      #1;
      checkOutput("mid_cs_before", mem_cs, 1);
      rst = 1'b0;
      #1;
      checkOutput("mid_cs", mem_cs, 0);
      checkOutput("mid_stall", stall, 0);
      checkOutput("mid_done", done, 0);
      @(negedge clk);
      #1;
      checkOutput("mid_done_later", done, 0);
      checkOutput("mid_fault_later", fault, 0);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(LOAD, 3'd2, 32'h44, 32'h0, 32'h13579BDF, 1);
      checkOutput("post_rst_done", saw_done, 1);
      checkOutput("post_rst_stalls", n_stall, 2);
      checkOutput("post_rst_rdata", cap_rdata, 32'h13579BDF);

      // Misaligned halfword store.
      applyStimulus(STORE, 3'd1, 32'h101, 32'h00001234, 32'h0, 1);
      checkOutput("mis_done", saw_done, 1);
`ifdef LSU_MISALIGN_TRAP_EN
      checkOutput("mis_fault", cap_fault, 1);
      checkOutput("mis_cs_cycles", n_cs, 0);
      checkOutput("mis_stalls", n_stall, 1);
      checkOutput("mis_rdata", cap_rdata, 0);
`else
      checkOutput("mis_fault", cap_fault, 0);
      checkOutput("mis_stalls", n_stall, 2);
      checkOutput("mis_mask", cap_mask, 4'h3);
      checkOutput("mis_addr", cap_addr, 32'h100);
      checkOutput("mis_wdata", cap_wdata, 32'h12341234);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
